// File: rtl/wr_ptr_ctrl_if.sv
// Write-side FIFO pointer bus: client request/status plus the Gray pointers
// that cross into and out of the read domain.
interface wr_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W:0]   rd_ptr_gray;
    logic              ovf_clr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_ptr_gray;
    logic              wr_full;
    logic              wr_almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              wr_overflow;

    modport master (
        output wr_en, rd_ptr_gray, ovf_clr,
        input  wr_addr, wr_ptr_gray, wr_full, wr_almost_full, wr_level, wr_overflow
    );

    modport slave (
        input  wr_en, rd_ptr_gray, ovf_clr,
        output wr_addr, wr_ptr_gray, wr_full, wr_almost_full, wr_level, wr_overflow
    );
endinterface

// File: rtl/wr_ptr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, read-pointer
// synchroniser and registered full / almost-full / level / overflow flags.
module wr_ptr_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int AF_THRESH   = 2**ADDR_W - 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wr_clk,
    input  logic        wr_rst_n,
    wr_ptr_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_THRESH);

    logic [ADDR_W:0]                  r_wbin;
    logic [ADDR_W:0]                  r_gray;
    logic [SYNC_STAGES-1:0][ADDR_W:0] r_sync;
    logic                             r_full;
    logic                             r_af;
    logic [ADDR_W:0]                  r_level;
    logic                             r_ovf;

    logic            w_acc;
    logic [ADDR_W:0] w_wbin_next;
    logic [ADDR_W:0] w_gray_next;
    logic [ADDR_W:0] w_rq;
    logic [ADDR_W:0] w_rbin;
    logic [ADDR_W:0] w_level_next;
    logic            w_full_next;

    assign w_acc       = bus.wr_en & ~r_full;
    assign w_wbin_next = r_wbin + {{ADDR_W{1'b0}}, w_acc};
    assign w_gray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_rq        = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDR_W; i++)
            w_rbin[i] = ^(w_rq >> i);
    end

    // Level and full are judged against the (stale) synchronised read pointer,
    // so they can only err towards "more full" -- never an overrun.
    assign w_level_next = w_wbin_next - w_rbin;
    assign w_full_next  = (w_gray_next == {~w_rq[ADDR_W:ADDR_W-1], w_rq[ADDR_W-2:0]});

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rd_ptr_gray};
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_wbin  <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_gray  <= w_gray_next;
            r_full  <= w_full_next;
            r_af    <= (w_level_next >= AF_L);
            r_level <= w_level_next;
            // Set beats clear so a blocked write in the clearing cycle is not lost.
            r_ovf   <= (bus.wr_en & r_full) | (r_ovf & ~bus.ovf_clr);
        end
    end

    assign bus.wr_addr        = r_wbin[ADDR_W-1:0];
    assign bus.wr_ptr_gray    = r_gray;
    assign bus.wr_full        = r_full;
    assign bus.wr_almost_full = r_af;
    assign bus.wr_level       = r_level;
    assign bus.wr_overflow    = r_ovf;
endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Bench for wr_ptr_ctrl: directed scenarios plus random traffic, every cycle
// compared against a counter-level model of the write side.
module tb_wr_ptr_ctrl;
    localparam int AW    = 3;
    localparam int DEPTH = 2**AW;
    localparam int PW    = 2*DEPTH;
    localparam int AF    = 6;
    localparam int SYNC  = 2;

    logic wr_clk = 1'b0;
    logic wr_rst_n = 1'b0;
    always #5 wr_clk = ~wr_clk;

    wr_ptr_ctrl_if #(.ADDR_W(AW)) bus ();

    wr_ptr_ctrl #(.ADDR_W(AW), .AF_THRESH(AF), .SYNC_STAGES(SYNC)) dut (
        .wr_clk  (wr_clk),
        .wr_rst_n(wr_rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: write count modulo 2*DEPTH, read pointer seen SYNC edges late,
    // flags derived from the occupancy difference.
    int           m_wcnt;
    int           m_level;
    bit           m_full, m_af, m_ovf;
    logic [AW:0]  m_rd_hist [SYNC];

    function automatic int gdec(logic [AW:0] g);
        for (int i = 0; i < PW; i++)
            if (AW'(0) == 0 && (i ^ (i >> 1)) == int'(g)) return i;
        return 0;
    endfunction

    function automatic int nxt_w();
        return (m_wcnt + ((bus.wr_en && !m_full) ? 1 : 0)) % PW;
    endfunction

    function automatic int nxt_lvl();
        return (nxt_w() - gdec(m_rd_hist[SYNC-1]) + PW) % PW;
    endfunction

    always @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            m_wcnt  <= 0;
            m_level <= 0;
            m_full  <= 1'b0;
            m_af    <= 1'b0;
            m_ovf   <= 1'b0;
            for (int i = 0; i < SYNC; i++) m_rd_hist[i] <= '0;
        end else begin
            m_wcnt  <= nxt_w();
            m_level <= nxt_lvl();
            m_full  <= (nxt_lvl() == DEPTH);
            m_af    <= (nxt_lvl() >= AF);
            m_ovf   <= (bus.wr_en && m_full) || (m_ovf && !bus.ovf_clr);
            m_rd_hist[0] <= bus.rd_ptr_gray;
            for (int i = 1; i < SYNC; i++) m_rd_hist[i] <= m_rd_hist[i-1];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp();
        chk("addr",  int'(bus.wr_addr), m_wcnt % DEPTH);
        chk("gray",  int'(bus.wr_ptr_gray), m_wcnt ^ (m_wcnt >> 1));
        chk("full",  int'(bus.wr_full), int'(m_full));
        chk("af",    int'(bus.wr_almost_full), int'(m_af));
        chk("level", int'(bus.wr_level), m_level);
        chk("ovf",   int'(bus.wr_overflow), int'(m_ovf));
    endtask

    // Drive inputs just after a falling edge, then compare at the next one.
    task automatic cyc(input bit we, input logic [AW:0] rp, input bit clr);
        bus.wr_en       = we;
        bus.rd_ptr_gray = rp;
        bus.ovf_clr     = clr;
        @(posedge wr_clk);
        @(negedge wr_clk);
        cmp();
    endtask

    task automatic do_reset();
        bus.wr_en = 1'b0; bus.rd_ptr_gray = '0; bus.ovf_clr = 1'b0;
        #2 wr_rst_n = 1'b0;
        @(negedge wr_clk);
        cmp();
        wr_rst_n = 1'b1;
    endtask

    logic [AW:0] prev_g;
    logic [AW:0] rp;
    int          rcnt;

    initial begin
        bus.wr_en = 1'b0; bus.rd_ptr_gray = '0; bus.ovf_clr = 1'b0;
        @(negedge wr_clk);
        cmp();
        chk("rst_level", int'(bus.wr_level), 0);
        chk("rst_full",  int'(bus.wr_full), 0);
        wr_rst_n = 1'b1;

        // Fill, almost-full rising at level 6
        for (int i = 0; i < DEPTH; i++) begin
            chk("t1_addr", int'(bus.wr_addr), i);
            cyc(1'b1, '0, 1'b0);
            chk("t2_af", int'(bus.wr_almost_full), (i + 1 >= 6) ? 1 : 0);
        end
        chk("t1_full",  int'(bus.wr_full), 1);
        chk("t1_level", int'(bus.wr_level), 8);
        chk("t1_gray",  int'(bus.wr_ptr_gray), 4'b1100);
        chk("t1_ovf",   int'(bus.wr_overflow), 0);

        // Overflow set / set-beats-clear / clear
        cyc(1'b1, '0, 1'b0);
        chk("t3_addr", int'(bus.wr_addr), 0);
        chk("t3_gray", int'(bus.wr_ptr_gray), 4'b1100);
        chk("t3_ovf",  int'(bus.wr_overflow), 1);
        cyc(1'b1, '0, 1'b1);
        chk("t3_ovf_setwins", int'(bus.wr_overflow), 1);
        cyc(1'b0, '0, 1'b1);
        chk("t3_ovf_clr", int'(bus.wr_overflow), 0);

        // Read pointer advance: full drops after SYNC+1 edges
        cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("t4_full_hold", int'(bus.wr_full), 1);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("t4_full_drop", int'(bus.wr_full), 0);
        chk("t4_level",     int'(bus.wr_level), 7);
        cyc(1'b1, 4'b0001, 1'b0);
        chk("t4_refull", int'(bus.wr_full), 1);
        chk("t4_gray",   int'(bus.wr_ptr_gray), 4'b1101);

        // Wrap with the read pointer tracking accepted writes
        do_reset();
        prev_g = bus.wr_ptr_gray;
        for (int i = 1; i <= 20; i++) begin
            rp = AW'(0) == 0 ? (AW+1)'(m_wcnt ^ (m_wcnt >> 1)) : '0;
            cyc(1'b1, rp, 1'b0);
            chk("t5_hamming", $countones(bus.wr_ptr_gray ^ prev_g), 1);
            prev_g = bus.wr_ptr_gray;
            if (i == 16) chk("t5_wrap_gray", int'(bus.wr_ptr_gray), 0);
        end

        // Asynchronous reset between edges at level 5
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, '0, 1'b0);
        chk("t6_level5", int'(bus.wr_level), 5);
        #2 wr_rst_n = 1'b0;
        #1;
        chk("t6_async_level", int'(bus.wr_level), 0);
        chk("t6_async_addr",  int'(bus.wr_addr), 0);
        chk("t6_async_af",    int'(bus.wr_almost_full), 0);
        cmp();
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        chk("t6_first_addr", int'(bus.wr_addr), 0);
        cyc(1'b1, '0, 1'b0);
        chk("t6_after_write", int'(bus.wr_addr), 1);

        // Random traffic; the read side never passes the accepted writes
        do_reset();
        rcnt = 0;
        for (int n = 0; n < 600; n++) begin
            if (((m_wcnt - rcnt + PW) % PW) != 0 && $urandom_range(0, 99) < 35)
                rcnt = (rcnt + 1) % PW;
            rp = (AW+1)'(rcnt ^ (rcnt >> 1));
            cyc($urandom_range(0, 99) < 65, rp, $urandom_range(0, 99) < 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
Write-side pointer and flag controller for the async FIFO, generalised from the fixed-width write pointer block.
- Keeps a binary write pointer with a wrap bit and exports it Gray-coded for CDC.
- Synchronises the incoming Gray read pointer internally.
- Produces registered full, almost-full, fill-level and sticky overflow status for the write domain.
- Sits between the write-side client and the dual-port RAM / read-pointer block.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; legal range 2..12
AF_THRESH, 2**ADDR_W-2, fill level at or above which wr_almost_full asserts; legal range 1..2**ADDR_W
SYNC_STAGES, 2, flops in the rd_ptr_gray synchroniser; legal range 2..4

Ports:
wr_clk  input  1  write-domain clock; all state on rising edge
wr_rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request from client
rd_ptr_gray  input  ADDR_W+1  Gray read pointer from read domain (asynchronous to wr_clk)
ovf_clr  input  1  clears wr_overflow
wr_addr  output  ADDR_W  RAM write address (binary, low ADDR_W bits of pointer)
wr_ptr_gray  output  ADDR_W+1  registered Gray write pointer to read domain
wr_full  output  1  FIFO full (registered)
wr_almost_full  output  1  level >= AF_THRESH (registered)
wr_level  output  ADDR_W+1  fill level as seen from write domain, 0..2**ADDR_W
wr_overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (wr_rst_n low, async): binary ptr, wr_ptr_gray, all synchroniser flops, wr_full, wr_almost_full, wr_level and wr_overflow all = 0.
- Reset deassertion is applied on the next wr_clk edge after release.
- Reset mid-operation discards all state; no flag survives.
- Accept: acc = wr_en & ~wr_full. Data is written to RAM at wr_addr in the same cycle acc is high.
- Pointer update: wbin_next = wbin + acc, modulo 2**(ADDR_W+1). The wrap bit toggles naturally at the depth boundary. wr_addr = wbin[ADDR_W-1:0].
- Gray: wr_ptr_gray <= wbin_next ^ (wbin_next >> 1). It is registered, so it changes at most 1 bit per edge.
- Synchroniser: rq = rd_ptr_gray after SYNC_STAGES wr_clk flops. No logic is placed between the synchroniser flops.
- Full: wr_full <= (gray(wbin_next) == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}).
  - Full asserts on the same edge that accepts the last free entry (zero-latency, no overrun).
  - Full deasserts SYNC_STAGES+1 edges after rd_ptr_gray advances (pessimistic by design).
- Level: wr_level <= wbin_next - gray2bin(rq), modulo 2**(ADDR_W+1). It never exceeds 2**ADDR_W.
- Almost full: wr_almost_full <= (level_next >= AF_THRESH). It is computed from the same next-state values as wr_level.
- Overflow:
  - Sets on any edge where wr_en & wr_full.
  - ovf_clr clears it.
  - Set wins over clear in the same cycle.
  - Overflowed writes do not move the pointer.
- Simultaneous write and read-pointer advance: both take effect. Level stays unchanged only once the read advance reaches rq.
- Full with wr_en held high: the pointer is frozen and overflow stays set. There is no wrap past the read pointer.

Test Plan:
ADDR_W=3, AF_THRESH=6, SYNC_STAGES=2, rd_ptr_gray held 0.
1. Reset, then 8 back-to-back wr_en cycles -> wr_addr steps 0..7; after 8th edge wr_full=1, wr_level=8, wr_ptr_gray=4'b1100, wr_overflow=0.
2. Same fill sequence -> wr_almost_full rises on the edge where wr_level becomes 6 and stays high through level 8.
3. Full, wr_en=1 one more cycle -> wbin unchanged, wr_addr=0, wr_overflow=1. Then ovf_clr=1 alongside a blocked write -> overflow stays 1. ovf_clr alone -> 0.
4. Full, set rd_ptr_gray=4'b0001 -> wr_full drops exactly 3 edges later and wr_level=7. Next write reasserts full, wr_ptr_gray=4'b1101.
5. Wrap test: 20 writes with rd_ptr_gray driven to track each accepted write -> wr_ptr_gray sequence is valid Gray (Hamming distance 1 per change), returns to 4'b0000 after 16 writes, wr_full never asserts.
6. Assert wr_rst_n low mid-fill (level 5, between clock edges) -> all outputs 0 immediately without a clock edge. After release, the first write uses wr_addr=0.
